// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar ranging front-end: FSM state codes,
// default timing constants and a small BCD helper.
package sonar_pkg;

  typedef enum logic [3:0] {
    EST_INICIAL       = 4'd0,
    EST_PREPARACAO    = 4'd1,
    EST_ENVIA_TRIGGER = 4'd2,
    EST_ESPERA_ECHO   = 4'd3,
    EST_MEDIDA        = 4'd4,
    EST_ARMAZENA      = 4'd5,
    EST_FINAL         = 4'd6
  } estado_t;

  // Defaults for a 50 MHz clock: 10 us trigger, 58.82 us per cm, 40 ms watchdog
  localparam int unsigned CICLOS_TRIGGER_PADRAO = 500;
  localparam int unsigned CICLOS_POR_CM_PADRAO  = 2941;
  localparam int unsigned CICLOS_TIMEOUT_PADRAO = 2_000_000;

  // True when the 3-decade BCD value has reached its ceiling of 999
  function automatic logic bcd_no_maximo(input logic [11:0] bcd);
    return (bcd == 12'h999);
  endfunction

endpackage

// File: rtl/contador_cm_bcd.sv
// Centimetre counter: a tick counter that advances the BCD count halfway
// through each centimetre period (giving round-to-nearest), feeding a
// 3-decade BCD counter that saturates at 999.
module contador_cm_bcd
  import sonar_pkg::*;
#(
  parameter int unsigned CICLOS_POR_CM = CICLOS_POR_CM_PADRAO
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_clear,
  input  logic        i_enable,
  output logic [11:0] o_bcd
);

  localparam int LarguraTick = (CICLOS_POR_CM > 1) ? $clog2(CICLOS_POR_CM) : 1;
  localparam logic [LarguraTick-1:0] TickMax  = LarguraTick'(CICLOS_POR_CM - 1);
  localparam logic [LarguraTick-1:0] TickMeio = LarguraTick'(CICLOS_POR_CM / 2);

  logic [LarguraTick-1:0] r_tick;
  logic [3:0]             r_unid;
  logic [3:0]             r_dez;
  logic [3:0]             r_cent;
  logic                   w_incrementa;
  logic                   w_saturado;

  assign o_bcd        = {r_cent, r_dez, r_unid};
  assign w_incrementa = i_enable && (r_tick == TickMeio);
  assign w_saturado   = bcd_no_maximo(o_bcd);

  // Tick counter wraps every centimetre period while echo is being timed
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tick <= '0;
    end else if (i_clear) begin
      r_tick <= '0;
    end else if (i_enable) begin
      r_tick <= (r_tick == TickMax) ? '0 : r_tick + 1'b1;
    end
  end

  // Cascaded decades; once at 999 further increments are dropped
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_unid <= '0;
      r_dez  <= '0;
      r_cent <= '0;
    end else if (i_clear) begin
      r_unid <= '0;
      r_dez  <= '0;
      r_cent <= '0;
    end else if (w_incrementa && !w_saturado) begin
      if (r_unid == 4'd9) begin
        r_unid <= 4'd0;
        if (r_dez == 4'd9) begin
          r_dez  <= 4'd0;
          r_cent <= r_cent + 4'd1;
        end else begin
          r_dez <= r_dez + 4'd1;
        end
      end else begin
        r_unid <= r_unid + 4'd1;
      end
    end
  end

endmodule

// File: rtl/medidor_distancia.sv
// Ultrasonic ranging front-end: fires a trigger pulse on request, times the
// echo width, converts it to rounded BCD centimetres and pulses pronto.
// Optional watchdog on echo wait/measure enabled by defining MEDIDOR_TIMEOUT_EN.
module medidor_distancia
  import sonar_pkg::*;
#(
  parameter int unsigned CICLOS_TRIGGER = CICLOS_TRIGGER_PADRAO,
  parameter int unsigned CICLOS_POR_CM  = CICLOS_POR_CM_PADRAO,
  parameter int unsigned CICLOS_TIMEOUT = CICLOS_TIMEOUT_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  localparam int LarguraTrig = $clog2(CICLOS_TRIGGER + 1);
  localparam logic [LarguraTrig-1:0] TrigMax = LarguraTrig'(CICLOS_TRIGGER);

  estado_t                r_estado;
  logic                   r_echo_meta;
  logic                   r_echo_sync;
  logic [LarguraTrig-1:0] r_trig_cnt;
  logic                   r_trigger;
  logic                   r_pronto;
  logic [11:0]            r_medida;
  logic [11:0]            w_bcd;
  logic                   w_clear;
  logic                   w_enable;

`ifdef MEDIDOR_TIMEOUT_EN
  localparam int LarguraWd = (CICLOS_TIMEOUT > 1) ? $clog2(CICLOS_TIMEOUT) : 1;
  localparam logic [LarguraWd-1:0] WdMax = LarguraWd'(CICLOS_TIMEOUT - 1);
  logic                 r_erro;
  logic [LarguraWd-1:0] r_wd_cnt;
  assign erro = r_erro;
`else
  // Without the watchdog a measurement can never fail, so erro stays low
  assign erro = 1'b0 & (|CICLOS_TIMEOUT);
`endif

  assign trigger   = r_trigger;
  assign medida    = r_medida;
  assign pronto    = r_pronto;
  assign db_estado = r_estado;
  assign w_clear   = (r_estado == EST_PREPARACAO);
  assign w_enable  = (r_estado == EST_MEDIDA) && r_echo_sync;

  // Two-stage synchronizer for the asynchronous echo pin
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_echo_meta <= 1'b0;
      r_echo_sync <= 1'b0;
    end else begin
      r_echo_meta <= echo;
      r_echo_sync <= r_echo_meta;
    end
  end

  contador_cm_bcd #(
    .CICLOS_POR_CM(CICLOS_POR_CM)
  ) u_contador (
    .i_clock  (clock),
    .i_reset_n(reset),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_bcd    (w_bcd)
  );

  // Measurement sequencer with registered trigger/pronto/medida outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado   <= EST_INICIAL;
      r_trig_cnt <= '0;
      r_trigger  <= 1'b0;
      r_pronto   <= 1'b0;
      r_medida   <= 12'h000;
`ifdef MEDIDOR_TIMEOUT_EN
      r_erro     <= 1'b0;
      r_wd_cnt   <= '0;
`endif
    end else begin
      r_pronto <= 1'b0;
      case (r_estado)
        EST_INICIAL: begin
          if (medir) r_estado <= EST_PREPARACAO;
        end
        EST_PREPARACAO: begin
          r_trig_cnt <= '0;
`ifdef MEDIDOR_TIMEOUT_EN
          r_wd_cnt   <= '0;
`endif
          r_estado   <= EST_ENVIA_TRIGGER;
        end
        EST_ENVIA_TRIGGER: begin
          if (r_trig_cnt == TrigMax) begin
            r_trigger <= 1'b0;
            r_estado  <= EST_ESPERA_ECHO;
          end else begin
            r_trigger  <= 1'b1;
            r_trig_cnt <= r_trig_cnt + 1'b1;
          end
        end
        EST_ESPERA_ECHO: begin
          if (r_echo_sync) r_estado <= EST_MEDIDA;
        end
        EST_MEDIDA: begin
          if (!r_echo_sync) r_estado <= EST_ARMAZENA;
        end
        EST_ARMAZENA: begin
          r_medida <= w_bcd;
`ifdef MEDIDOR_TIMEOUT_EN
          r_erro   <= 1'b0;
`endif
          r_pronto <= 1'b1;
          r_estado <= EST_FINAL;
        end
        EST_FINAL: begin
          r_estado <= EST_INICIAL;
        end
        default: begin
          r_estado <= EST_INICIAL;
        end
      endcase
`ifdef MEDIDOR_TIMEOUT_EN
      // Watchdog overrides the normal transition when the echo never ends
      if (r_estado == EST_ESPERA_ECHO || r_estado == EST_MEDIDA) begin
        if (r_wd_cnt == WdMax) begin
          r_wd_cnt <= '0;
          r_erro   <= 1'b1;
          r_pronto <= 1'b1;
          r_estado <= EST_FINAL;
        end else begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_medidor_distancia.sv
// Directed bench for medidor_distancia with scaled-down timing parameters.
// Expected distances come from a rounding model and flow through a scoreboard.
module tb_medidor_distancia;

  localparam int unsigned TbTrigger = 20;
  localparam int unsigned TbPorCm   = 20;
  localparam int unsigned TbTimeout = 5000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        medir = 1'b0;
  logic        echo  = 1'b0;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_estado;

  int          errorCount = 0;
  int          checkCount = 0;
  logic [11:0] expectedQ[$];
  logic [11:0] lastMedida = 12'h000;

  medidor_distancia #(
    .CICLOS_TRIGGER(TbTrigger),
    .CICLOS_POR_CM (TbPorCm),
    .CICLOS_TIMEOUT(TbTimeout)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .medir    (medir),
    .echo     (echo),
    .trigger  (trigger),
    .medida   (medida),
    .pronto   (pronto),
    .erro     (erro),
    .db_estado(db_estado)
  );

  // 50 MHz clock
  always #10 clock = ~clock;

  // Reference: echo width in clocks -> nearest centimetre, capped at 999, as BCD
  function automatic logic [11:0] modelBcd(input int unsigned width);
    int unsigned cm;
    cm = (width + TbPorCm / 2) / TbPorCm;
    if (cm > 999) cm = 999;
    return {4'(cm / 100), 4'((cm / 10) % 10), 4'(cm % 10)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitState(input logic [3:0] target, input int budget, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clock);
      if (db_estado == target) seen = 1'b1;
    end
  endtask

  task automatic waitPronto(input int budget, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clock);
      cycles++;
      if (pronto) seen = 1'b1;
    end
  endtask

  // One-cycle medir request, then wait until the trigger has finished
  task automatic startMeasure(input string tag);
    bit seen;
    @(negedge clock);
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    waitState(4'd3, 100, seen);
    checkOutput({tag, " reach espera_echo"}, seen, 1);
  endtask

  // Drive an echo of the given width and record the expected distance
  task automatic applyStimulus(input int unsigned width, input bit pulseMedir);
    echo = 1'b1;
    for (int i = 0; i < int'(width); i++) begin
      @(negedge clock);
      if (pulseMedir) medir = (i >= 10 && i < 13);
    end
    echo  = 1'b0;
    medir = 1'b0;
    expectedQ.push_back(modelBcd(width));
  endtask

  // Wait for pronto, pop the scoreboard and check result, erro and pulse width
  task automatic checkResult(input string tag, input bit expErro);
    bit          seen;
    int          cycles;
    int          extra;
    logic [11:0] expected;
    waitPronto(200, cycles, seen);
    checkOutput({tag, " pronto seen"}, seen, 1);
    expected   = expectedQ.pop_front();
    lastMedida = expected;
    checkOutput({tag, " medida"}, medida, expected);
    checkOutput({tag, " erro"}, erro, expErro);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (pronto) extra++;
    end
    checkOutput({tag, " extra pronto"}, extra, 0);
  endtask

  initial begin
    int  n;
    int  rise;
    int  hi;
    int  cycles;
    bit  seen;

    // Reset state
    reset = 1'b0;
    #200;
    checkOutput("reset trigger", trigger, 0);
    checkOutput("reset medida", medida, 12'h000);
    checkOutput("reset pronto", pronto, 0);
    checkOutput("reset erro", erro, 0);
    checkOutput("reset db_estado", db_estado, 4'd0);
    @(negedge clock);
    reset = 1'b1;

    // medir held 5 cycles: trigger delay and width
    @(negedge clock);
    medir = 1'b1;
    n = 0; rise = 0; hi = 0;
    while (n < 60) begin
      @(negedge clock);
      n++;
      if (n == 5) medir = 1'b0;
      if (trigger) begin
        hi++;
        if (rise == 0) rise = n;
      end
    end
    checkOutput("trigger rise delay", rise, 3);
    checkOutput("trigger width", hi, TbTrigger);
    checkOutput("waiting for echo", db_estado, 4'd3);

    // 100.3 cm with medir pulsed mid-echo (must be ignored)
    applyStimulus(2006, 1'b1);
    checkResult("echo 100cm", 1'b0);
    checkOutput("idle after 100cm", db_estado, 4'd0);

    startMeasure("74.8cm");
    applyStimulus(1496, 1'b0);
    checkResult("echo 74.8cm round up", 1'b0);

    startMeasure("170cm");
    applyStimulus(3400, 1'b0);
    checkResult("echo 170cm", 1'b0);

`ifdef MEDIDOR_TIMEOUT_EN
    // No echo: watchdog ends the measurement, medida keeps previous value
    startMeasure("timeout");
    waitPronto(TbTimeout + 100, cycles, seen);
    checkOutput("timeout pronto seen", seen, 1);
    checkOutput("timeout latency", cycles, TbTimeout);
    checkOutput("timeout erro", erro, 1);
    checkOutput("timeout medida kept", medida, lastMedida);
    repeat (5) @(negedge clock);
    startMeasure("after timeout");
    applyStimulus(34, 1'b0);
    checkResult("good echo clears erro", 1'b0);
`endif

    startMeasure("1.7cm");
    applyStimulus(34, 1'b0);
    checkResult("echo 1.7cm", 1'b0);

    startMeasure("0.3cm");
    applyStimulus(6, 1'b0);
    checkResult("echo 0.3cm", 1'b0);

`ifndef MEDIDOR_TIMEOUT_EN
    startMeasure("saturate");
    applyStimulus(25000, 1'b0);
    checkResult("echo saturates 999", 1'b0);
`endif

    startMeasure("pre-reset");
    applyStimulus(34, 1'b0);
    checkResult("echo before reset", 1'b0);

    // Reset while timing an echo
    startMeasure("mid reset");
    echo = 1'b1;
    waitState(4'd4, 50, seen);
    checkOutput("reached medida state", seen, 1);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("mid reset db_estado", db_estado, 4'd0);
    checkOutput("mid reset trigger", trigger, 0);
    checkOutput("mid reset pronto", pronto, 0);
    checkOutput("mid reset medida", medida, 12'h000);
    echo = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    startMeasure("after reset");
    applyStimulus(1496, 1'b0);
    checkResult("echo after reset", 1'b0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
